serial_addsub: RTL and testbench

- Bit-serial WIDTH-bit adder/subtractor built around a single full-adder cell, processing operands LSB-first, one bit per clock.
- Trades latency for area against the ripple-carry 8-bit adder; serves as the shared arithmetic engine for sequential datapaths in this codebase.
- Start/done handshake; result is held stable until the next operation is accepted.

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/serial_addsub_fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 131 +++++++++++++
 tb/tb_serial_addsub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM states and operation select.
package addsub_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic element of the serial engine.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ cin_i;
  assign co_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock, start/done handshake.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import addsub_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  fa_cell u_fa (
    .a_i  (opa_q[0]),
    .b_i  (opb_q[0]),
    .cin_i(carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert B and seed the carry with 1.
          opa_d   = a;
          opb_d   = (sub == OP_SUB) ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cout_d  = fa_co;
`ifdef SERIAL_ADDSUB_OVF_EN
          // On the MSB cycle carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand shift registers carry data only; their content is don't-care until captured.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: timing-level reference model plus directed vectors.
`timescale 1ns/1ps
module tb_serial_addsub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .result(result),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference arithmetic: {cout, result}
  function automatic logic [WIDTH:0] ref_op(input logic s, input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    if (s) return {(x >= y), WIDTH'(x - y)};
    return (WIDTH+1)'(x) + (WIDTH+1)'(y);
  endfunction

  function automatic logic ref_ovf(input logic s, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
    int sx, sy, r;
    sx = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
    sy = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
    r  = s ? sx - sy : sx + sy;
    return (r > (1 << (WIDTH-1)) - 1) || (r < -(1 << (WIDTH-1)));
  endfunction

  // Model: an accepted start yields done WIDTH edges later; results held otherwise.
  int               m_left = 0;
  logic             m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [WIDTH-1:0] m_res = '0;
  logic [WIDTH-1:0] p_res = '0;
  logic             p_cout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_res  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= p_res;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end
    end else if (start) begin
      {p_cout, p_res} <= ref_op(sub, a, b);
      p_ovf  <= ref_ovf(sub, a, b);
      m_left <= WIDTH;
      m_busy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      if (!m_busy) begin
        check("result", 32'(result), 32'(m_res));
        check("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  // Issue one operation from a negedge and return on the negedge where done is seen.
  task automatic run_op(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] er, input logic ec, input string tag);
    int lat = 0;
    int busy_n = 0;
    bit seen = 1'b0;
    start = 1'b1; sub = s; a = x; b = y;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        a = ~x;
        b = 8'h5A;
      end
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, " done timeout"}, 32'd0, 32'd1);
    check({tag, " latency"}, lat, WIDTH + 1);
    check({tag, " busy cycles"}, busy_n, WIDTH);
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " model result"}, 32'(m_res), 32'(er));
  endtask

  initial begin
    int dones;
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset result", 32'(result), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 8'd5,   8'd3,   8'd8,   1'b0, "add 5+3");
    @(negedge clk);
    run_op(1'b0, 8'd200, 8'd100, 8'd44,  1'b1, "add 200+100");
    run_op(1'b0, 8'd255, 8'd1,   8'd0,   1'b1, "add 255+1");
    run_op(1'b1, 8'd5,   8'd3,   8'd2,   1'b1, "sub 5-3");
    run_op(1'b1, 8'd3,   8'd5,   8'hFE,  1'b0, "sub 3-5");
    run_op(1'b1, 8'd0,   8'd0,   8'd0,   1'b1, "sub 0-0");
    repeat (2) @(negedge clk);

    // start pulsed while busy, operands changed mid-run
    dones = 0;
    start = 1'b1; sub = 1'b0; a = 8'd5; b = 8'd3;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      if (i == 4) begin start = 1'b0; a = 8'd77; b = 8'd99; end
      if (done) dones++;
    end
    check("busy-start done pulses", dones, 1);
    check("busy-start result", 32'(result), 32'd8);

    // back-to-back: second start issued in the done cycle
    run_op(1'b0, 8'd5, 8'd3, 8'd8, 1'b0, "b2b first");
    check("b2b in done cycle", 32'(done), 32'd1);
    run_op(1'b1, 8'd10, 8'd4, 8'd6, 1'b1, "b2b 10-4");

    // reset in RUN cycle 4
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'd5; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst cout", 32'(cout), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst no done", dones, 0);
    run_op(1'b0, 8'd200, 8'd100, 8'd44, 1'b1, "after reset 200+100");

`ifdef SERIAL_ADDSUB_OVF_EN
    run_op(1'b0, 8'd127, 8'd1, 8'h80, 1'b0, "ovf 127+1");
    check("ovf 127+1 flag", 32'(ovf), 32'd1);
    run_op(1'b1, 8'h80, 8'd1, 8'h7F, 1'b1, "ovf 0x80-1");
    check("ovf 0x80-1 flag", 32'(ovf), 32'd1);
    run_op(1'b0, 8'd5, 8'd3, 8'd8, 1'b0, "ovf 5+3");
    check("ovf 5+3 flag", 32'(ovf), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
